// File: rtl/l1_input_conditioner.sv
// L1 input conditioner: syncs raw SURF L1 lines into clk250, then per channel
// edge-detects, stretches, masks and blocks stuck-high lines.
// Ports: clk250_i, rst_n_i (async low); L1_i, mask_i, stretch_i,
// stuck_limit_i in; L1_o (conditioned), edge_o (raw rise), stuck_o out.
module l1_input_conditioner #(
  parameter int NUM_SURFS = 12,
  parameter int NUM_TRIG  = 4,
  parameter int STUCK_W   = 16
) (
  input  logic                           clk250_i,
  input  logic                           rst_n_i,
  input  logic [NUM_SURFS*NUM_TRIG-1:0]  L1_i,
  input  logic [NUM_SURFS*NUM_TRIG-1:0]  mask_i,
  input  logic [3:0]                     stretch_i,
  input  logic [STUCK_W-1:0]             stuck_limit_i,
  output logic [NUM_SURFS*NUM_TRIG-1:0]  L1_o,
  output logic [NUM_SURFS*NUM_TRIG-1:0]  edge_o,
  output logic [NUM_SURFS*NUM_TRIG-1:0]  stuck_o
);

  localparam int N = NUM_SURFS * NUM_TRIG;

  logic [N-1:0] s1_q, s2_q, s3_q;
  logic [N-1:0] rise;
  logic         lim_off;

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= L1_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise    = s2_q & ~s3_q;
  assign lim_off = (stuck_limit_i == '0);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic               l1_q, edge_q, stuck_q;
    logic [3:0]         cnt_q;
    logic [STUCK_W-1:0] hcnt_q;
    logic [STUCK_W:0]   hinc;
    logic               stuck_set;
    logic               qual;

    // one bit wider so the compare cannot wrap at saturation
    assign hinc      = {1'b0, hcnt_q} + {{STUCK_W{1'b0}}, 1'b1};
    assign stuck_set = s2_q[i] & ~lim_off
                     & (hinc >= {1'b0, stuck_limit_i});
    assign qual      = rise[i] & ~mask_i[i] & ~stuck_q;

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        l1_q    <= 1'b0;
        edge_q  <= 1'b0;
        stuck_q <= 1'b0;
        cnt_q   <= '0;
        hcnt_q  <= '0;
      end else begin
        edge_q <= rise[i];

        if (!s2_q[i] || lim_off) begin
          hcnt_q  <= '0;
          stuck_q <= 1'b0;
        end else begin
          if (hcnt_q != '1) hcnt_q <= hinc[STUCK_W-1:0];
          if (stuck_set) stuck_q <= 1'b1;
        end

        // stuck and mask kill the pulse ahead of any new edge
        if (stuck_set || mask_i[i]) begin
          l1_q  <= 1'b0;
          cnt_q <= '0;
        end else if (qual) begin
          l1_q  <= 1'b1;
          cnt_q <= stretch_i;
        end else if (l1_q && cnt_q != '0) begin
          cnt_q <= cnt_q - 4'd1;
        end else if (cnt_q == '0) begin
          l1_q <= 1'b0;
        end
      end
    end

    assign L1_o[i]    = l1_q;
    assign edge_o[i]  = edge_q;
    assign stuck_o[i] = stuck_q;
  end

endmodule
